pipeline_hazard_unit: RTL and testbench
=======================================

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of in-flight stages after ID that can hold a pending register write (EX..WB commit).
REQ-002 The block SHALL have parameter LOAD_READY, default 2, meaning the first stage index (1 = EX) at which load data is forwardable.
REQ-003 The block SHALL have parameter REG_W, default 5, meaning the register id width.
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning the width of each performance counter.
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 id_rs, id_rt  input  REG_W each  source register ids.
REQ-009 id_rs_used, id_rt_used  input  1 each  the instruction actually reads that source.
REQ-010 id_wr_en, id_wr_id, id_is_load  input  1/REG_W/1  pending write of the ID instruction.
REQ-011 ex_redirect  input  1  taken branch or jump resolved in EX this cycle.
REQ-012 ext_hold  input  1  memory not ready; freezes the whole pipeline.
REQ-013 stall  output  1  hold PC and IF/ID, and insert a bubble into EX.
REQ-014 flush_id  output  1  discard the IF/ID contents.
REQ-015 fwd_rs_sel, fwd_rt_sel  output  $clog2(DEPTH+1) each  0 = register file; k = result of stage k.
REQ-016 stall_count, flush_count  output  CNT_W each  saturating event counters.

Function
REQ-017 The block SHALL keep a DEPTH-entry shadow pipeline; each entry is {valid, wr_en, wr_id, is_load}; entry 1 is EX and entry DEPTH is the stage committing to the register file this cycle.
REQ-018 An entry k SHALL match source s only if valid=1, wr_en=1, wr_id==s, s!=0, and the corresponding *_used input is 1.
REQ-019 fwd_*_sel SHALL equal the smallest matching k (youngest producer), or 0 if no entry matches; outputs are combinational from the current entries and ID inputs.
REQ-020 Load-use: if the youngest match for either source has is_load=1 and k<LOAD_READY, stall SHALL be 1 (id_valid=1 required).
REQ-021 stall SHALL also be 1 whenever ext_hold=1.
REQ-022 On ex_redirect=1 with ext_hold=0, flush_id SHALL be 1 and the load-use stall SHALL be suppressed: the ID instruction is discarded.
REQ-023 On ext_hold=1, no entry SHALL shift, flush_id SHALL be 0, and neither counter SHALL change.
REQ-024 Shift rule with ext_hold=0: entries k SHALL move to k+1 and entry DEPTH SHALL retire. Entry 1 SHALL load the ID fields when id_valid=1, stall=0 and flush_id=0; otherwise entry 1 SHALL become a bubble (valid=0).
REQ-025 Priority SHALL be ext_hold > ex_redirect > load-use stall.
REQ-026 stall_count SHALL increment by 1 each cycle with a load-use stall and ext_hold=0; flush_count SHALL increment by 1 each cycle with flush_id=1.
REQ-027 Both counters SHALL saturate at all-ones and never wrap.
REQ-028 A write to register 0 SHALL never create a hazard or a forward.

Reset
REQ-029 While rst=0, all entries SHALL have valid=0 and both counters SHALL be 0; hence stall=0, flush_id=0 and fwd_*_sel=0 unless driven by inputs (ex_redirect/ext_hold).
REQ-030 Assertion of rst mid-operation SHALL discard all in-flight entries immediately, without waiting for a clock edge.
REQ-031 The first rising edge after rst deasserts SHALL perform a normal shift.

Structure
REQ-032 A shared package SHALL hold typedef hz_entry_t, typedef fwd_sel_t, and the defaults for DEPTH, LOAD_READY and REG_W.
REQ-033 One sub-module, sat_counter (parameter CNT_W; inputs clk, rst, inc; output count), SHALL be instantiated twice.
REQ-034 No other sub-modules SHALL be used.

Verification
REQ-035 Back-to-back ALU: add $3 then add $4,$3,$3 -> fwd_rs_sel=1, fwd_rt_sel=1, stall=0.
REQ-036 Load-use: lw $5 then add $6,$5,$0 -> one cycle with stall=1 and fwd_rs_sel=0 (fwd_rt_sel=0, $0 never forwards); next cycle fwd_rs_sel=2, stall=0; stall_count=1.
REQ-037 Writes to $7 in stages 1 and 3 while ID reads $7 -> fwd_rs_sel=1 (youngest wins).
REQ-038 ex_redirect=1 coincident with a load-use hazard -> flush_id=1, stall=0, entry 1 becomes a bubble; flush_count=1, stall_count=0.
REQ-039 ext_hold=1 for 3 cycles with a pending hazard -> entries frozen and counters unchanged; hazard resolves normally after release.
REQ-040 Counters preset near max: drive 5 flushes with CNT_W=4 from count 13 -> flush_count stays at 15; rst=0 mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and parameter defaults for the pipeline hazard unit.
//   hz_entry_t : one shadow-pipeline slot {valid, wr_en, wr_id, is_load}
//   fwd_sel_t  : internal forward-select code (0 = regfile, k = stage k)
package pipeline_hazard_unit_pkg;

  localparam int unsigned DEPTH_DEF      = 4;
  localparam int unsigned LOAD_READY_DEF = 2;
  localparam int unsigned REG_W_DEF      = 5;

  // Storage width for register ids and select codes; covers REG_W <= 8, DEPTH <= 15.
  localparam int unsigned HZ_ID_W    = 8;
  localparam int unsigned SEL_MAX_W  = 4;

  typedef struct packed {
    logic               valid;
    logic               wr_en;
    logic [HZ_ID_W-1:0] wr_id;
    logic               is_load;
  } hz_entry_t;

  typedef logic [SEL_MAX_W-1:0] fwd_sel_t;

  localparam hz_entry_t HZ_BUBBLE = '0;

endpackage

// File: rtl/pipeline_hazard_unit_sat_counter.sv
// Saturating event counter: counts up by one per cycle with inc=1, sticks at all-ones.
//   clk, rst (async active-low), inc -> count
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection / forwarding unit for an in-order pipeline.
// Tracks pending register writes of the DEPTH stages after ID and produces:
//   stall       : hold PC and IF/ID, bubble into EX (load-use or ext_hold)
//   flush_id    : discard IF/ID on a redirect resolved in EX
//   fwd_*_sel   : 0 = register file, k = result of stage k (youngest producer)
//   *_count     : saturating load-use stall / flush event counters
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned LOAD_READY = LOAD_READY_DEF,
  parameter int unsigned REG_W      = REG_W_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_W-1:0]           id_rs,
  input  logic [REG_W-1:0]           id_rt,
  input  logic                       id_rs_used,
  input  logic                       id_rt_used,
  input  logic                       id_wr_en,
  input  logic [REG_W-1:0]           id_wr_id,
  input  logic                       id_is_load,
  input  logic                       ex_redirect,
  input  logic                       ext_hold,
  output logic                       stall,
  output logic                       flush_id,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs_sel,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rt_sel,
  output logic [CNT_W-1:0]           stall_count,
  output logic [CNT_W-1:0]           flush_count
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  // ent_q[k] models stage k+1 (index 0 = EX, DEPTH-1 = committing stage).
  hz_entry_t ent_q [DEPTH];
  hz_entry_t ent_d [DEPTH];

  fwd_sel_t rs_sel, rt_sel;
  logic     rs_unready, rt_unready;
  logic     load_use;
  logic     stall_inc;

  // Youngest-producer search: scanning old->young lets the youngest overwrite.
  always_comb begin
    rs_sel     = '0;
    rt_sel     = '0;
    rs_unready = 1'b0;
    rt_unready = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_q[k].valid && ent_q[k].wr_en && id_rs_used && (id_rs != '0) &&
          (ent_q[k].wr_id == HZ_ID_W'(id_rs))) begin
        rs_sel     = fwd_sel_t'(k + 1);
        rs_unready = ent_q[k].is_load && ((k + 1) < int'(LOAD_READY));
      end
      if (ent_q[k].valid && ent_q[k].wr_en && id_rt_used && (id_rt != '0) &&
          (ent_q[k].wr_id == HZ_ID_W'(id_rt))) begin
        rt_sel     = fwd_sel_t'(k + 1);
        rt_unready = ent_q[k].is_load && ((k + 1) < int'(LOAD_READY));
      end
    end
    // Load data not yet available: nothing to forward, the stall covers it.
    if (rs_unready) rs_sel = '0;
    if (rt_unready) rt_sel = '0;
  end

  // Control with priority ext_hold > ex_redirect > load-use.
  always_comb begin
    load_use   = id_valid && (rs_unready || rt_unready);
    flush_id   = ex_redirect && !ext_hold;
    stall      = ext_hold || (load_use && !ex_redirect);
    stall_inc  = load_use && !ex_redirect && !ext_hold;
    fwd_rs_sel = SEL_W'(rs_sel);
    fwd_rt_sel = SEL_W'(rt_sel);
  end

  // Shadow pipeline advance; frozen under ext_hold.
  always_comb begin
    ent_d = ent_q;
    if (!ext_hold) begin
      for (int k = DEPTH - 1; k > 0; k--) ent_d[k] = ent_q[k-1];
      if (id_valid && !stall && !flush_id) begin
        ent_d[0].valid   = 1'b1;
        ent_d[0].wr_en   = id_wr_en;
        ent_d[0].wr_id   = HZ_ID_W'(id_wr_id);
        ent_d[0].is_load = id_is_load;
      end else begin
        ent_d[0] = HZ_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= HZ_BUBBLE;
    end else begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= ent_d[k];
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_id),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit (DEPTH=4, LOAD_READY=2, REG_W=5, CNT_W=4).
module tb_pipeline_hazard_unit;

  localparam int unsigned D  = 4;
  localparam int unsigned LR = 2;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 3;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_wr_id = '0;
  logic          id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic          id_wr_en = 1'b0, id_is_load = 1'b0;
  logic          ex_redirect = 1'b0, ext_hold = 1'b0;
  logic          stall, flush_id;
  logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_unit #(.DEPTH(D), .LOAD_READY(LR), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_id(id_wr_id), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .ext_hold(ext_hold), .stall(stall), .flush_id(flush_id),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight writers, element 0 = EX.
  typedef struct {bit v; bit wr; int id; bit ld;} ment_t;
  typedef struct {bit stall; bit flush; int rs_sel; int rt_sel; int sc; int fc;} exp_t;

  ment_t pipe[$];
  exp_t  expq[$];
  int    m_sc = 0, m_fc = 0;
  int    n_chk = 0, n_pass = 0;

  function automatic void lookup(input int src, input bit used, output int sel, output bit haz);
    bit found;
    sel = 0; haz = 1'b0; found = 1'b0;
    if (used && src != 0) begin
      for (int k = 0; k < pipe.size(); k++) begin
        if (!found && pipe[k].v && pipe[k].wr && pipe[k].id == src) begin
          found = 1'b1;
          if (pipe[k].ld && (k + 1) < int'(LR)) haz = 1'b1;
          else sel = k + 1;
        end
      end
    end
  endfunction

  task automatic model_clear();
    pipe.delete();
    for (int k = 0; k < int'(D); k++) pipe.push_back('{1'b0, 1'b0, 0, 1'b0});
    m_sc = 0; m_fc = 0;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
  endtask

  // One cycle: drive inputs just after posedge, push expectation, advance model for next edge.
  task automatic step(input bit r, input bit v, input int rs, input int rt,
                      input bit rsu, input bit rtu, input bit we, input int wid,
                      input bit ld, input bit redir, input bit hold);
    exp_t  e;
    int    s1, s2;
    bit    h1, h2, lu;
    ment_t n;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs = RW'(rs); id_rt = RW'(rt);
    id_rs_used = rsu; id_rt_used = rtu; id_wr_en = we; id_wr_id = RW'(wid);
    id_is_load = ld; ex_redirect = redir; ext_hold = hold;
    if (!r) model_clear();
    lookup(rs, rsu, s1, h1);
    lookup(rt, rtu, s2, h2);
    lu      = v && (h1 || h2);
    e.stall = hold || (lu && !redir);
    e.flush = redir && !hold;
    e.rs_sel = s1; e.rt_sel = s2; e.sc = m_sc; e.fc = m_fc;
    expq.push_back(e);
    if (r && !hold) begin
      if (lu && !redir && m_sc < CMAX) m_sc++;
      if (e.flush && m_fc < CMAX) m_fc++;
      n = '{v && !e.stall && !e.flush, we, wid, ld};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic nop(input bit r);
    step(r, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall",       int'(stall),       int'(e.stall));
      chk("flush_id",    int'(flush_id),    int'(e.flush));
      chk("fwd_rs_sel",  int'(fwd_rs_sel),  e.rs_sel);
      chk("fwd_rt_sel",  int'(fwd_rt_sel),  e.rt_sel);
      chk("stall_count", int'(stall_count), e.sc);
      chk("flush_count", int'(flush_count), e.fc);
    end
  end

  initial begin
    model_clear();
    nop(1'b0); nop(1'b0);
    nop(1'b1);

    // Back-to-back ALU: add $3 ; add $4,$3,$3
    step(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    // Load-use: lw $5 ; add $6,$5,$0 (held one cycle)
    step(1, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    step(1, 1, 5, 0, 1, 1, 1, 6, 0, 0, 0);
    step(1, 1, 5, 0, 1, 1, 1, 6, 0, 0, 0);
    // Two writers of $7 in stages 1 and 3
    step(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    nop(1'b1);
    step(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step(1, 1, 7, 7, 1, 0, 1, 2, 0, 0, 0);
    // Write to $0 never forwards
    step(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 1, 1, 2, 0, 0, 0);

    // Redirect coincident with load-use, from clean counters
    nop(1'b0); nop(1'b1);
    step(1, 1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    step(1, 1, 8, 0, 1, 0, 1, 9, 0, 1, 0);
    nop(1'b1); nop(1'b1);

    // ext_hold for three cycles over a pending load-use
    step(1, 1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    repeat (3) step(1, 1, 9, 9, 1, 1, 1, 10, 0, 0, 1);
    repeat (2) step(1, 1, 9, 9, 1, 1, 1, 10, 0, 0, 0);

    // Flush counter saturation, then async reset mid-stream
    nop(1'b0); nop(1'b1);
    repeat (18) step(1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 1, 11, 1, 0, 0);
    step(1, 1, 11, 0, 1, 0, 1, 12, 0, 0, 0);
    step(0, 1, 11, 0, 1, 0, 1, 12, 0, 1, 0);
    nop(1'b0); nop(1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 9) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    repeat (3) @(posedge clk);
    if (expq.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
